// File: rtl/alu64_pkg.sv
// Opcode encoding shared by the ALU top level and its bench.
package alu64_pkg;

    typedef enum logic [1:0] {
        ADD = 2'b00,
        SUB = 2'b01,
        AND = 2'b10,
        XOR = 2'b11
    } opcode_e;

endpackage

// File: rtl/alu64_addsub.sv
// Combinational adder/subtractor: sub inverts b and injects a carry-in of 1.
module alu64_addsub #(
    parameter int WIDTH = 64
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic [WIDTH-1:0] sum,
    output logic             carry,
    output logic             overflow
);

    logic [WIDTH-1:0] b_eff;
    logic [WIDTH:0]   full;

    assign b_eff = sub ? ~b : b;
    assign full  = {1'b0, a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, sub};
    assign sum   = full[WIDTH-1:0];
    assign carry = full[WIDTH];

    // Same-signed effective operands producing a differently-signed sum.
    assign overflow = (a[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);

endmodule

// File: rtl/alu64.sv
// Registered two's-complement ALU (add, sub, and, xor) with overflow and zero flags.
// Defining ALU64_CARRY_EN adds a registered carry/borrow output.
module alu64
    import alu64_pkg::*;
#(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [1:0]       opcode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] res,
`ifdef ALU64_CARRY_EN
    output logic             carry,
`endif
    output logic             overflow,
    output logic             zero,
    output logic             out_valid
);

    opcode_e          op;
    logic [WIDTH-1:0] as_sum;
    logic             as_carry;
    logic             as_overflow;

    logic [WIDTH-1:0] res_d, res_q;
    logic             overflow_d, overflow_q;
    logic             zero_d, zero_q;
    logic             out_valid_q;

    assign op = opcode_e'(opcode);

    alu64_addsub #(
        .WIDTH (WIDTH)
    ) u_addsub (
        .a        (a),
        .b        (b),
        .sub      (op == SUB),
        .sum      (as_sum),
        .carry    (as_carry),
        .overflow (as_overflow)
    );

    always_comb begin
        res_d      = '0;
        overflow_d = 1'b0;
        unique case (op)
            ADD, SUB: begin
                res_d      = as_sum;
                overflow_d = as_overflow;
            end
            AND:     res_d = a & b;
            XOR:     res_d = a ^ b;
            default: res_d = '0;
        endcase
        zero_d = (res_d == '0);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            res_q       <= '0;
            overflow_q  <= 1'b0;
            zero_q      <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            out_valid_q <= in_valid;
            if (in_valid) begin
                res_q      <= res_d;
                overflow_q <= overflow_d;
                zero_q     <= zero_d;
            end
        end
    end

`ifdef ALU64_CARRY_EN
    logic carry_d, carry_q;

    // The adder reports "no borrow" as carry-out 1 on subtraction.
    always_comb begin
        carry_d = 1'b0;
        if (op == ADD) carry_d = as_carry;
        else if (op == SUB) carry_d = ~as_carry;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            carry_q <= 1'b0;
        end else if (in_valid) begin
            carry_q <= carry_d;
        end
    end

    assign carry = carry_q;
`else
    logic unused_carry;
    assign unused_carry = as_carry;
`endif

    assign res       = res_q;
    assign overflow  = overflow_q;
    assign zero      = zero_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_alu64.sv
// Directed-vector bench for alu64; set ALU64_CARRY_EN to also exercise the carry output.
module tb_alu64;
    import alu64_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [1:0]  opcode;
    logic [63:0] a, b;
    logic [63:0] res;
    logic        overflow, zero, out_valid;
`ifdef ALU64_CARRY_EN
    logic        carry;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    alu64 #(
        .WIDTH (64)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .opcode    (opcode),
        .a         (a),
        .b         (b),
        .res       (res),
`ifdef ALU64_CARRY_EN
        .carry     (carry),
`endif
        .overflow  (overflow),
        .zero      (zero),
        .out_valid (out_valid)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [63:0] e_res, input logic e_ovf,
                             input logic e_zero, input logic e_vld);
        check({tag, ".res"}, res, e_res);
        check({tag, ".overflow"}, {63'd0, overflow}, {63'd0, e_ovf});
        check({tag, ".zero"}, {63'd0, zero}, {63'd0, e_zero});
        check({tag, ".out_valid"}, {63'd0, out_valid}, {63'd0, e_vld});
    endtask

    // Apply one operation for a single clock, then sample #1 after the edge.
    task automatic do_op(input logic vld, input opcode_e op, input logic [63:0] x,
                         input logic [63:0] y);
        in_valid = vld;
        opcode   = op;
        a        = x;
        b        = y;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n    = 1'b0;
        in_valid = 1'b0;
        opcode   = ADD;
        a        = '0;
        b        = '0;
        @(posedge clk);
        @(posedge clk);
        #1;
        check_all("reset", 64'd0, 1'b0, 1'b0, 1'b0);
`ifdef ALU64_CARRY_EN
        check("reset.carry", {63'd0, carry}, 64'd0);
`endif
        rst_n = 1'b1;

        do_op(1'b1, ADD, 64'd5, 64'd7);
        check_all("add_5_7", 64'd12, 1'b0, 1'b0, 1'b1);

        do_op(1'b1, ADD, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1);
        check_all("add_ovf", 64'h8000_0000_0000_0000, 1'b1, 1'b0, 1'b1);
`ifdef ALU64_CARRY_EN
        check("add_ovf.carry", {63'd0, carry}, 64'd0);
`endif

        do_op(1'b1, SUB, 64'd16, 64'd8);
        check_all("sub_16_8", 64'd8, 1'b0, 1'b0, 1'b1);

        do_op(1'b1, SUB, 64'd8, 64'd8);
        check_all("sub_8_8", 64'd0, 1'b0, 1'b1, 1'b1);
`ifdef ALU64_CARRY_EN
        check("sub_8_8.carry", {63'd0, carry}, 64'd0);
`endif

        do_op(1'b1, SUB, 64'h8000_0000_0000_0000, 64'd1);
        check_all("sub_ovf", 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, 1'b1);

        do_op(1'b1, SUB, 64'd3, 64'h8000_0000_0000_0000);
        check_all("sub_neg_ovf", 64'h8000_0000_0000_0003, 1'b1, 1'b0, 1'b1);

`ifdef ALU64_CARRY_EN
        do_op(1'b1, SUB, 64'd0, 64'd1);
        check_all("sub_borrow", 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, 1'b1);
        check("sub_borrow.carry", {63'd0, carry}, 64'd1);

        do_op(1'b1, ADD, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1);
        check_all("add_carry", 64'd0, 1'b0, 1'b1, 1'b1);
        check("add_carry.carry", {63'd0, carry}, 64'd1);
`endif

        do_op(1'b1, AND, 64'hF0F0, 64'h0FF0);
        check_all("and", 64'h00F0, 1'b0, 1'b0, 1'b1);
`ifdef ALU64_CARRY_EN
        check("and.carry", {63'd0, carry}, 64'd0);
`endif

        do_op(1'b1, AND, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000);
        check_all("and_msb", 64'h8000_0000_0000_0000, 1'b0, 1'b0, 1'b1);

        do_op(1'b1, XOR, 64'hFFFF, 64'hFFFF);
        check_all("xor_zero", 64'd0, 1'b0, 1'b1, 1'b1);

        do_op(1'b1, XOR, 64'hA5A5_0000_0000_00FF, 64'h0F0F_0000_0000_0F0F);
        check_all("xor", 64'hAAAA_0000_0000_0FF0, 1'b0, 1'b0, 1'b1);

        // Hold: an idle cycle keeps the last result but drops out_valid.
        do_op(1'b1, ADD, 64'h7FFF_FFFF_FFFF_FFFF, 64'h7FFF_FFFF_FFFF_FFFF);
        check_all("pre_hold", 64'hFFFF_FFFF_FFFF_FFFE, 1'b1, 1'b0, 1'b1);
        do_op(1'b0, XOR, 64'd9, 64'd9);
        check_all("hold", 64'hFFFF_FFFF_FFFF_FFFE, 1'b1, 1'b0, 1'b0);

        // Reset wins over a simultaneous valid operation.
        rst_n = 1'b0;
        do_op(1'b1, ADD, 64'd1, 64'd1);
        check_all("rst_prio", 64'd0, 1'b0, 1'b0, 1'b0);
`ifdef ALU64_CARRY_EN
        check("rst_prio.carry", {63'd0, carry}, 64'd0);
`endif
        rst_n = 1'b1;
        do_op(1'b0, ADD, 64'd1, 64'd1);
        check_all("post_rst", 64'd0, 1'b0, 1'b0, 1'b0);

        do_op(1'b1, SUB, 64'd1, 64'd3);
        check_all("sub_neg", 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/alu64.md
ALU64 -- requirements
Module: alu64

Interface
REQ-001 The block SHALL have parameter WIDTH, default 64, meaning operand and result width in bits.
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1, reset that is synchronous and active-low.
REQ-004 The block SHALL have port in_valid, input, 1, meaning the operands and opcode are valid this cycle.
REQ-005 The block SHALL have port opcode, input, 2, meaning operation select: 00 add, 01 sub, 10 and, 11 xor.
REQ-006 The block SHALL have port a, input, WIDTH, meaning first operand, two's-complement signed.
REQ-007 The block SHALL have port b, input, WIDTH, meaning second operand, two's-complement signed.
REQ-008 The block SHALL have port res, output, WIDTH, meaning registered result.
REQ-009 The block SHALL have port overflow, output, 1, meaning registered signed overflow flag.
REQ-010 The block SHALL have port zero, output, 1, meaning registered flag, 1 when res is all zeros.
REQ-011 The block SHALL have port out_valid, output, 1, meaning res and the flags are valid this cycle.

Function
REQ-012 The block SHALL compute, for opcode 00, res = a + b modulo 2^WIDTH.
REQ-013 The block SHALL compute, for opcode 01, res = a - b modulo 2^WIDTH (first operand minus second).
REQ-014 The block SHALL compute, for opcode 10, res = bitwise a AND b.
REQ-015 The block SHALL compute, for opcode 11, res = bitwise a XOR b.
REQ-016 The block SHALL assert overflow for add when sign(a) == sign(b) and sign(res) != sign(a).
REQ-017 The block SHALL assert overflow for sub when sign(a) != sign(b) and sign(res) != sign(a).
REQ-018 The block SHALL hold overflow at 0 for the and and xor operations.
REQ-019 The block SHALL set zero to 1 exactly when the new res equals 0, for every opcode.
REQ-020 The block SHALL have a latency of one cycle: inputs sampled at edge N with in_valid=1 appear on res, overflow, zero at edge N, with out_valid=1 in the following cycle.
REQ-021 The block SHALL hold res, overflow and zero at their previous values on a cycle where in_valid=0, and drive out_valid=0 in the next cycle.
REQ-022 The block SHALL accept back-to-back operations every cycle with no stall and no handshake back-pressure.
REQ-023 The block SHALL discard any carry or borrow out of bit WIDTH-1 from res.

Reset
REQ-024 The block SHALL clear res, overflow, zero and out_valid to 0 on a rising clk edge when rst_n=0.
REQ-025 The block SHALL give rst_n=0 priority over in_valid=1 in the same cycle; that operation is discarded.
REQ-026 The block SHALL discard an operation sampled in the cycle where reset is asserted mid-stream, with no output for it after reset deasserts.

Configuration
REQ-027 The block SHALL add, when macro ALU64_CARRY_EN is defined, output port carry (1 bit, registered with the same timing as res) that equals the unsigned carry-out for add, the borrow (a < b unsigned) for sub, and 0 for and/xor; carry resets to 0.
REQ-028 The block SHALL have neither the carry port nor its logic when ALU64_CARRY_EN is undefined; all other behaviour is identical.

Structure
REQ-029 The block SHALL take the opcode encoding as a typedef and the four opcode constants (ADD, SUB, AND, XOR) from package alu64_pkg.
REQ-030 The block SHALL instantiate one sub-module, alu64_addsub, a combinational WIDTH-bit adder/subtractor (b inverted plus carry-in 1 for sub) producing the sum, the carry-out and the signed overflow; logic ops and output registers sit in alu64.

Verification
REQ-031 The bench SHALL check: add a=5, b=7 -> res=12, overflow=0, zero=0, out_valid=1 one cycle later.
REQ-032 The bench SHALL check: add a=0x7FFF_FFFF_FFFF_FFFF, b=1 -> res=0x8000_0000_0000_0000, overflow=1.
REQ-033 The bench SHALL check: sub a=16, b=8 -> res=8, then sub a=8, b=8 -> res=0, zero=1, overflow=0.
REQ-034 The bench SHALL check: sub a=0x8000_0000_0000_0000, b=1 -> res=0x7FFF_FFFF_FFFF_FFFF, overflow=1; with ALU64_CARRY_EN, sub a=0, b=1 -> carry=1.
REQ-035 The bench SHALL check: and 0xF0F0, 0x0FF0 -> 0x00F0; xor 0xFFFF, 0xFFFF -> 0, zero=1, overflow=0.
REQ-036 The bench SHALL check: rst_n=0 asserted together with in_valid=1 -> all outputs 0 next cycle; in_valid=0 -> outputs hold and out_valid=0.
